mem_rr_arbiter: RTL and testbench
=================================

Name: mem_rr_arbiter

Overview:
Round-robin arbiter sharing one single-port synchronous RAM (the team's `memory` block: rd/wr/addr/din/dout, dout registered one cycle after rd) between two requesters, A and B. Each requester issues single-word read or write commands with a req/gnt handshake and receives read data with an rvalid pulse. The arbiter owns every memory control pin, so rd and wr are never asserted together.

Parameters:
Addr_width, 10, memory address width
Data_width, 8, memory data width
Cnt_width, 16, width of the grant counters (optional feature only)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-low (0 = reset)
a_req  input  1  A requests an access; held until a_gnt
a_we  input  1  A: 1 = write, 0 = read; stable while a_req
a_addr  input  Addr_width  A address; stable while a_req
a_wdata  input  Data_width  A write data; stable while a_req
a_gnt  output  1  one-cycle pulse: A's command is on the memory bus
a_rvalid  output  1  one-cycle pulse: a_rdata valid
a_rdata  output  Data_width  A read data
b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as A, for requester B
mem_rd  output  1  to memory rd
mem_wr  output  1  to memory wr
mem_addr  output  Addr_width  to memory addr
mem_din  output  Data_width  to memory din
mem_dout  input  Data_width  from memory dout; valid the cycle after mem_rd
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (rst=0 at an edge): state=IDLE; every output = 0; last_gnt=B, so A wins the first tie. Any in-flight read is dropped and produces no rvalid.
- FSM states: IDLE, ISSUE, RDWAIT.
- IDLE, no req: stay in IDLE; mem_rd=mem_wr=0.
- IDLE, any req: pick the winner.
  - Only one requester active: that requester wins.
  - Both active: the requester not equal to last_gnt wins.
  - At the next edge: register mem_addr/mem_din from the winner; set mem_wr=we or mem_rd=~we; set the winner's gnt=1; update last_gnt; go to ISSUE.
- ISSUE (1 cycle): command on the memory bus, gnt high.
  - At the next edge: mem_rd, mem_wr and gnt clear.
  - Write: go to IDLE.
  - Read: go to RDWAIT and remember the owner.
- RDWAIT (1 cycle): mem_dout holds the read data. At the next edge: capture mem_dout into the owner's rdata, pulse the owner's rvalid for 1 cycle, go to IDLE.
- rdata holds its value until the next read for that requester completes.
- Latency from req sampled in IDLE:
  - gnt at +1 cycle.
  - rvalid at +3 cycles.
  - Write throughput: 1 per 2 cycles. Read throughput: 1 per 3 cycles.
- Handshake rules:
  - A requester drops req, or presents its next command, in the cycle after gnt.
  - req is ignored outside IDLE. No request is ever lost while held.
- Both requesters continuously active: grants strictly alternate A, B, A, B.
- mem_addr and mem_din hold their last values when idle. Only mem_rd and mem_wr qualify the bus.
- Same-address write-then-read by different requesters: serialized in grant order. The read returns the newly written value.
- rst=0 in any state: takes effect at that edge, overriding all transitions.

Optional Feature:
MEM_ARB_STATS_EN
- Defined: adds outputs a_gnt_cnt and b_gnt_cnt, each Cnt_width wide.
  - Each counter increments on every gnt pulse of its requester.
  - Wraps from all-ones to 0.
  - Cleared by reset.
- Undefined: ports and counters absent. Arbitration identical.

Test Plan:
- Reset then A writes 0x5A @addr 3 (a_req=1, a_we=1) -> a_gnt at cycle+1 with mem_wr=1, mem_addr=3, mem_din=0x5A. Then A reads addr 3 -> a_rvalid at +3 cycles with a_rdata=0x5A; b_rvalid stays 0.
- A and B both assert req in the same cycle from reset -> A granted first, then B. Held continuously for 8 grants -> strict alternation A,B,A,B,A,B,A,B.
- A writes 0x11 to addr 1023, then B reads addr 1023 -> b_rdata=0x11. Check address wrap edge: addr 0 unaffected, reads its prior value.
- B only requests, 4 reads back-to-back -> b_gnt every 3 cycles; mem_rd and mem_wr never both 1; busy low only in IDLE cycles.
- rst=0 asserted during RDWAIT -> no rvalid pulse. All outputs 0 the next cycle. The first post-reset tie is granted to A.
- With MEM_ARB_STATS_EN: 5 A grants and 3 B grants -> a_gnt_cnt=5, b_gnt_cnt=3. Preload to 0xFFFF via 65535 grants, one more -> 0.

Source files
------------

// File: rtl/mem_rr_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
// Define MEM_ARB_STATS_EN to add per-requester grant counters.
module mem_rr_arbiter #(
  parameter int Addr_width = 10,
  parameter int Data_width = 8,
  parameter int Cnt_width  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [Addr_width-1:0] a_addr,
  input  logic [Data_width-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [Data_width-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [Addr_width-1:0] b_addr,
  input  logic [Data_width-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [Data_width-1:0] b_rdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [Addr_width-1:0] mem_addr,
  output logic [Data_width-1:0] mem_din,
  input  logic [Data_width-1:0] mem_dout,
  output logic                  busy
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [Cnt_width-1:0]  a_gnt_cnt,
  output logic [Cnt_width-1:0]  b_gnt_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_RDWAIT = 2'd2
  } state_t;

  if (Cnt_width < 1) begin : g_bad_cnt_width
    $error("Cnt_width must be at least 1");
  end

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_last_gnt_b;   // 1 = B held the most recent grant
  logic                  r_owner_b;
  logic                  r_we;
  logic [Addr_width-1:0] r_mem_addr;
  logic [Data_width-1:0] r_mem_din;
  logic                  r_a_rvalid;
  logic                  r_b_rvalid;
  logic [Data_width-1:0] r_a_rdata;
  logic [Data_width-1:0] r_b_rdata;
  logic                  w_any_req;
  logic                  w_win_b;
  logic                  w_accept;

  assign w_any_req = a_req | b_req;
  // B wins when alone, or on a tie when A was granted last.
  assign w_win_b   = b_req & (~a_req | ~r_last_gnt_b);
  assign w_accept  = (r_state == S_IDLE) & w_any_req;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_any_req) w_next_state = S_ISSUE;
      S_ISSUE:  w_next_state = r_we ? S_IDLE : S_RDWAIT;
      S_RDWAIT: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    mem_rd = (r_state == S_ISSUE) & ~r_we;
    mem_wr = (r_state == S_ISSUE) &  r_we;
    a_gnt  = (r_state == S_ISSUE) & ~r_owner_b;
    b_gnt  = (r_state == S_ISSUE) &  r_owner_b;
    busy   = (r_state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last_gnt_b <= 1'b1;
      r_owner_b    <= 1'b0;
      r_we         <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_din    <= '0;
      r_a_rvalid   <= 1'b0;
      r_b_rvalid   <= 1'b0;
      r_a_rdata    <= '0;
      r_b_rdata    <= '0;
    end else begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      if (w_accept) begin
        r_owner_b    <= w_win_b;
        r_last_gnt_b <= w_win_b;
        r_we         <= w_win_b ? b_we    : a_we;
        r_mem_addr   <= w_win_b ? b_addr  : a_addr;
        r_mem_din    <= w_win_b ? b_wdata : a_wdata;
      end
      if (r_state == S_RDWAIT) begin
        if (r_owner_b) begin
          r_b_rdata  <= mem_dout;
          r_b_rvalid <= 1'b1;
        end else begin
          r_a_rdata  <= mem_dout;
          r_a_rvalid <= 1'b1;
        end
      end
    end
  end

  assign mem_addr = r_mem_addr;
  assign mem_din  = r_mem_din;
  assign a_rvalid = r_a_rvalid;
  assign b_rvalid = r_b_rvalid;
  assign a_rdata  = r_a_rdata;
  assign b_rdata  = r_b_rdata;

`ifdef MEM_ARB_STATS_EN
  logic [Cnt_width-1:0] r_a_gnt_cnt;
  logic [Cnt_width-1:0] r_b_gnt_cnt;

  // Counted at the accepting edge, so the new value is visible with gnt.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_a_gnt_cnt <= '0;
      r_b_gnt_cnt <= '0;
    end else if (w_accept) begin
      if (w_win_b) r_b_gnt_cnt <= r_b_gnt_cnt + 1'b1;
      else         r_a_gnt_cnt <= r_a_gnt_cnt + 1'b1;
    end
  end

  assign a_gnt_cnt = r_a_gnt_cnt;
  assign b_gnt_cnt = r_b_gnt_cnt;
`endif

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter with a behavioural single-port RAM model.
// With MEM_ARB_STATS_EN the counters are built 4 bits wide to reach wrap quickly.
module tb_mem_rr_arbiter;

`ifdef MEM_ARB_STATS_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       a_req = 1'b0, a_we = 1'b0;
  logic [9:0] a_addr = '0;
  logic [7:0] a_wdata = '0;
  logic       b_req = 1'b0, b_we = 1'b0;
  logic [9:0] b_addr = '0;
  logic [7:0] b_wdata = '0;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic       mem_rd, mem_wr, busy;
  logic [9:0] mem_addr;
  logic [7:0] mem_din;
  logic [7:0] mem_dout = '0;
`ifdef MEM_ARB_STATS_EN
  logic [CW-1:0] a_gnt_cnt, b_gnt_cnt;
`endif

  mem_rr_arbiter #(.Addr_width(10), .Data_width(8), .Cnt_width(CW)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .busy(busy)
`ifdef MEM_ARB_STATS_EN
    , .a_gnt_cnt(a_gnt_cnt), .b_gnt_cnt(b_gnt_cnt)
`endif
  );

  always #5 clk = ~clk;

  // RAM model: write on wr, dout registered one cycle after rd.
  logic [7:0] ram [1024];
  initial for (int i = 0; i < 1024; i++) ram[i] = 8'hC3;
  always @(posedge clk) begin
    if (mem_wr) ram[mem_addr] <= mem_din;
    if (mem_rd) mem_dout <= ram[mem_addr];
  end

  bit excl_err = 1'b0;
  always @(negedge clk) if ((mem_rd && mem_wr) || (a_gnt && b_gnt)) excl_err = 1'b1;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ctl = {a_gnt, b_gnt, mem_rd, mem_wr, busy, a_rvalid, b_rvalid}
  typedef struct {
    logic       ar, awe;
    logic [9:0] aad;
    logic [7:0] awd;
    logic       br, bwe;
    logic [9:0] bad;
    logic [7:0] bwd;
    logic [6:0] ctl;
    logic [9:0] addr;
    logic [7:0] din, ard, brd;
  } vec_t;

  function automatic vec_t mk(input logic ar, awe, input logic [9:0] aad, input logic [7:0] awd,
                              input logic br, bwe, input logic [9:0] bad, input logic [7:0] bwd,
                              input logic [6:0] ctl, input logic [9:0] addr,
                              input logic [7:0] din, ard, brd);
    vec_t v;
    v.ar = ar; v.awe = awe; v.aad = aad; v.awd = awd;
    v.br = br; v.bwe = bwe; v.bad = bad; v.bwd = bwd;
    v.ctl = ctl; v.addr = addr; v.din = din; v.ard = ard; v.brd = brd;
    return v;
  endfunction

  function automatic logic [6:0] ctl_now();
    return {a_gnt, b_gnt, mem_rd, mem_wr, busy, a_rvalid, b_rvalid};
  endfunction

  task automatic do_cmd(input logic is_b, input logic we, input logic [9:0] addr, input logic [7:0] data);
    int  n;
    bit  got;
    n = 0;
    got = 1'b0;
    if (is_b) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = data; end
    else      begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = data; end
    while (!got && n < 10) begin
      tick();
      got = is_b ? b_gnt : a_gnt;
      n++;
    end
    a_req = 1'b0;
    b_req = 1'b0;
    if (!got) check("cmd_gnt_timeout", 32'd0, 32'd1);
    for (int k = 0; k < 3; k++) tick();
  endtask

  vec_t tbl [19];

  initial begin
    int g_cnt, rv_cnt;
    logic [31:0] g_cyc [8];
    logic        g_isb [8];

    // A write/read, B read of A's write at the top address, tie after B.
    tbl[0]  = mk(1,1,10'h003,8'h5A, 0,0,10'h000,8'h00, 7'b1001100,10'h003,8'h5A,8'h00,8'h00);
    tbl[1]  = mk(1,1,10'h003,8'h5A, 0,0,10'h000,8'h00, 7'b0000000,10'h003,8'h5A,8'h00,8'h00);
    tbl[2]  = mk(1,0,10'h003,8'h00, 0,0,10'h000,8'h00, 7'b1010100,10'h003,8'h00,8'h00,8'h00);
    tbl[3]  = mk(1,0,10'h003,8'h00, 0,0,10'h000,8'h00, 7'b0000100,10'h003,8'h00,8'h00,8'h00);
    tbl[4]  = mk(0,0,10'h003,8'h00, 0,0,10'h000,8'h00, 7'b0000010,10'h003,8'h00,8'h5A,8'h00);
    tbl[5]  = mk(0,0,10'h003,8'h00, 0,0,10'h000,8'h00, 7'b0000000,10'h003,8'h00,8'h5A,8'h00);
    tbl[6]  = mk(1,1,10'h3FF,8'h11, 0,0,10'h000,8'h00, 7'b1001100,10'h3FF,8'h11,8'h5A,8'h00);
    tbl[7]  = mk(1,1,10'h3FF,8'h11, 1,0,10'h3FF,8'h00, 7'b0000000,10'h3FF,8'h11,8'h5A,8'h00);
    tbl[8]  = mk(0,0,10'h3FF,8'h11, 1,0,10'h3FF,8'h00, 7'b0110100,10'h3FF,8'h00,8'h5A,8'h00);
    tbl[9]  = mk(0,0,10'h3FF,8'h11, 1,0,10'h3FF,8'h00, 7'b0000100,10'h3FF,8'h00,8'h5A,8'h00);
    tbl[10] = mk(0,0,10'h3FF,8'h11, 1,0,10'h000,8'h00, 7'b0000001,10'h3FF,8'h00,8'h5A,8'h11);
    tbl[11] = mk(0,0,10'h3FF,8'h11, 1,0,10'h000,8'h00, 7'b0110100,10'h000,8'h00,8'h5A,8'h11);
    tbl[12] = mk(0,0,10'h3FF,8'h11, 1,0,10'h000,8'h00, 7'b0000100,10'h000,8'h00,8'h5A,8'h11);
    tbl[13] = mk(0,0,10'h3FF,8'h11, 0,0,10'h000,8'h00, 7'b0000001,10'h000,8'h00,8'h5A,8'hC3);
    tbl[14] = mk(1,1,10'h005,8'h77, 1,1,10'h006,8'h66, 7'b1001100,10'h005,8'h77,8'h5A,8'hC3);
    tbl[15] = mk(1,1,10'h005,8'h77, 1,1,10'h006,8'h66, 7'b0000000,10'h005,8'h77,8'h5A,8'hC3);
    tbl[16] = mk(0,1,10'h005,8'h77, 1,1,10'h006,8'h66, 7'b0101100,10'h006,8'h66,8'h5A,8'hC3);
    tbl[17] = mk(0,1,10'h005,8'h77, 1,1,10'h006,8'h66, 7'b0000000,10'h006,8'h66,8'h5A,8'hC3);
    tbl[18] = mk(0,1,10'h005,8'h77, 0,1,10'h006,8'h66, 7'b0000000,10'h006,8'h66,8'h5A,8'hC3);

    tick();
    tick();
    check("reset_ctl",   {25'd0, ctl_now()}, 32'd0);
    check("reset_addr",  {22'd0, mem_addr},  32'd0);
    check("reset_data",  {8'd0, mem_din, a_rdata, b_rdata}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 19; i++) begin
      a_req = tbl[i].ar; a_we = tbl[i].awe; a_addr = tbl[i].aad; a_wdata = tbl[i].awd;
      b_req = tbl[i].br; b_we = tbl[i].bwe; b_addr = tbl[i].bad; b_wdata = tbl[i].bwd;
      tick();
      check($sformatf("vec%0d_ctl", i),  {25'd0, ctl_now()}, {25'd0, tbl[i].ctl});
      check($sformatf("vec%0d_bus", i),  {14'd0, mem_addr, mem_din}, {14'd0, tbl[i].addr, tbl[i].din});
      check($sformatf("vec%0d_rdata", i), {16'd0, a_rdata, b_rdata}, {16'd0, tbl[i].ard, tbl[i].brd});
    end

    // Both requesters held from reset: grants alternate A,B,... every 2 cycles.
    rst = 1'b0;
    a_req = 1'b1; a_we = 1'b1; a_addr = 10'd20; a_wdata = 8'hAA;
    b_req = 1'b1; b_we = 1'b1; b_addr = 10'd21; b_wdata = 8'hBB;
    tick();
    rst = 1'b1;
    g_cnt = 0;
    for (int c = 1; c <= 40 && g_cnt < 8; c++) begin
      tick();
      if (a_gnt || b_gnt) begin
        g_cyc[g_cnt] = c;
        g_isb[g_cnt] = b_gnt;
        g_cnt++;
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    check("alt_grant_count", g_cnt, 8);
    for (int k = 0; k < g_cnt; k++) begin
      check($sformatf("alt_grant%0d_owner", k), {31'd0, g_isb[k]}, k % 2);
      check($sformatf("alt_grant%0d_cycle", k), g_cyc[k], 2 * k + 1);
    end
    tick();
    tick();

    // B alone, four back-to-back reads of addr 3: one grant per 3 cycles.
    b_req = 1'b1; b_we = 1'b0; b_addr = 10'd3; b_wdata = 8'h00;
    g_cnt = 0;
    rv_cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (b_gnt && g_cnt < 8) begin
        g_cyc[g_cnt] = c;
        g_cnt++;
        if (g_cnt == 4) b_req = 1'b0;
      end
      if (b_rvalid) rv_cnt++;
    end
    check("brd_grant_count", g_cnt, 4);
    check("brd_rvalid_count", rv_cnt, 4);
    for (int k = 0; k < 4 && k < g_cnt; k++)
      check($sformatf("brd_grant%0d_cycle", k), g_cyc[k], 3 * k + 1);
    check("brd_rdata", {24'd0, b_rdata}, 32'h5A);
    check("brd_a_rvalid_quiet", {31'd0, a_rvalid}, 32'd0);

    // Reset while in RDWAIT drops the read; first tie afterwards goes to A.
    a_req = 1'b1; a_we = 1'b0; a_addr = 10'd3;
    tick();
    check("rstrd_gnt", {31'd0, a_gnt}, 32'd1);
    a_req = 1'b0;
    tick();
    check("rstrd_in_rdwait", {25'd0, ctl_now()}, 32'b0000100);
    rst = 1'b0;
    tick();
    check("rstrd_ctl_zero",  {25'd0, ctl_now()}, 32'd0);
    check("rstrd_data_zero", {6'd0, mem_addr, a_rdata, b_rdata}, 32'd0);
    rst = 1'b1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 10'd7; a_wdata = 8'h01;
    b_req = 1'b1; b_we = 1'b1; b_addr = 10'd8; b_wdata = 8'h02;
    tick();
    check("rstrd_no_late_rvalid", {31'd0, a_rvalid}, 32'd0);
    check("rstrd_tie_to_a", {30'd0, a_gnt, b_gnt}, 32'b10);
    a_req = 1'b0;
    b_req = 1'b0;
    tick();
    tick();

    // Address 0 must still hold its initial contents after the top-address write.
    do_cmd(1'b0, 1'b0, 10'd0, 8'h00);
    check("addr0_untouched", {24'd0, a_rdata}, 32'hC3);

`ifdef MEM_ARB_STATS_EN
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("cnt_reset", {24'd0, a_gnt_cnt, b_gnt_cnt}, 32'd0);
    for (int k = 0; k < 5; k++) do_cmd(1'b0, 1'b1, 10'd30, 8'h00);
    for (int k = 0; k < 3; k++) do_cmd(1'b1, 1'b1, 10'd31, 8'h00);
    check("cnt_a_5", {28'd0, a_gnt_cnt}, 32'd5);
    check("cnt_b_3", {28'd0, b_gnt_cnt}, 32'd3);
    for (int k = 0; k < 10; k++) do_cmd(1'b0, 1'b1, 10'd30, 8'h00);
    check("cnt_a_max", {28'd0, a_gnt_cnt}, 32'd15);
    do_cmd(1'b0, 1'b1, 10'd30, 8'h00);
    check("cnt_a_wrap", {28'd0, a_gnt_cnt}, 32'd0);
    check("cnt_b_hold", {28'd0, b_gnt_cnt}, 32'd3);
`endif

    check("rd_wr_gnt_exclusive", {31'd0, excl_err}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
